decode_issue_unit: RTL and testbench

- Parametrised, registered successor to the combinational instruction classifier.
- Accepts one instruction per handshake and decodes its 6-bit major opcode into a one-hot class {mem, jump, float, branch, alu}.
- Holds the instruction for a class-dependent number of cycles (models multi-cycle memory/FPU), then presents it downstream with valid/ready handshakes.
- Sits between fetch and the execution units; also counts issued instructions.

---
 rtl/decode_issue_unit.sv | 99 +++++++++
 tb/tb_decode_issue_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/decode_issue_unit.sv
// Registered decode/issue stage: classifies the major opcode, models class-dependent
// execution latency, and hands the instruction downstream over a valid/ready handshake.
module decode_issue_unit #(
   parameter int XLEN    = 32,
   parameter int OPC_MSB = XLEN - 1,
   parameter int MEM_LAT = 3,
   parameter int FPU_LAT = 4,
   parameter int CNT_W   = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] instruction,
   input  logic [XLEN-1:0] pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [4:0]      out_class,
   output logic [XLEN-1:0] out_instr,
   output logic [XLEN-1:0] out_pc,
   output logic            busy,
   output logic [15:0]     issue_count
);

   typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

   localparam logic [CNT_W-1:0] MEM_L = CNT_W'(MEM_LAT);
   localparam logic [CNT_W-1:0] FPU_L = CNT_W'(FPU_LAT);
   localparam logic [CNT_W-1:0] ONE_L = CNT_W'(1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [4:0]       cls;
   logic [5:0]       opcode;
   logic [2:0]       first;
   logic [2:0]       second;
   logic [4:0]       dec_class;
   logic [CNT_W-1:0] lat;
   logic             accept;

   // Class bits are {mem, jump, float, branch, alu}; the encodings partition the opcode space.
   always_comb begin
      opcode    = instruction[OPC_MSB -: 6];
      first     = opcode[5:3];
      second    = opcode[2:0];
      dec_class = '0;
      dec_class[0] = (first < 3'b011);
      dec_class[1] = first[2] & ~first[1];
      dec_class[2] = first[2] & first[1];
      dec_class[3] = (first == 3'b011) & (second < 3'b101);
      dec_class[4] = (first == 3'b011) & (second >= 3'b101);
      lat = ONE_L;
      if (dec_class[4]) lat = MEM_L;
      else if (dec_class[2]) lat = FPU_L;
   end

   assign in_ready  = (state == IDLE) | ((state == HOLD) & out_ready);
   assign accept    = in_valid & in_ready;
   assign out_valid = (state == HOLD);
   assign out_class = out_valid ? cls : 5'd0;
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         cls         <= '0;
         out_instr   <= '0;
         out_pc      <= '0;
         issue_count <= '0;
      end else begin
         case (state)
            IDLE, HOLD: begin
               if (accept) begin
                  out_instr   <= instruction;
                  out_pc      <= pc;
                  cls         <= dec_class;
                  issue_count <= issue_count + 16'd1;
                  if (lat == ONE_L) begin
                     state <= HOLD;
                  end else begin
                     state <= EXEC;
                     cnt   <= lat - ONE_L;
                  end
               end else if (state == HOLD && out_ready) begin
                  state <= IDLE;
                  cls   <= '0;
               end
            end
            EXEC: begin
               if (cnt == ONE_L) state <= HOLD;
               else cnt <= cnt - ONE_L;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_decode_issue_unit.sv
// Randomized bench for decode_issue_unit, checked against a cycle-timestamp reference model.
module tb_decode_issue_unit;

   localparam int MEM_LAT = 3;
   localparam int FPU_LAT = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] instruction = '0;
   logic [31:0] pc = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [4:0]  out_class;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        busy;
   logic [15:0] issue_count;

   int total = 0;
   int bad = 0;

   // Model: an item is held from its accept edge and becomes visible L-1 edges later.
   logic        mItem = 1'b0;
   int          mReadyAt = 0;
   int          cyc = 0;
   logic [4:0]  mCls = '0;
   logic [31:0] mInstr = '0;
   logic [31:0] mPc = '0;
   logic [15:0] mCount = '0;

   decode_issue_unit #(
      .XLEN(32), .OPC_MSB(31), .MEM_LAT(MEM_LAT), .FPU_LAT(FPU_LAT), .CNT_W(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .instruction(instruction), .pc(pc), .out_valid(out_valid), .out_ready(out_ready),
      .out_class(out_class), .out_instr(out_instr), .out_pc(out_pc), .busy(busy),
      .issue_count(issue_count)
   );

   always #5 clk = ~clk;

   function automatic logic [4:0] refClass(input logic [31:0] ins);
      int op = int'(ins[31:26]);
      if (op < 24) return 5'b00001;
      if (op < 29) return 5'b01000;
      if (op < 32) return 5'b10000;
      if (op < 48) return 5'b00010;
      return 5'b00100;
   endfunction

   function automatic int refLat(input logic [4:0] c);
      if (c == 5'b10000) return MEM_LAT;
      if (c == 5'b00100) return FPU_LAT;
      return 1;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s observed=%0h expected=%0h at t=%0t", tag, observed, expected, $time);
      end
   endtask

   task automatic compareAll(input logic ordy);
      logic v = mItem && (cyc >= mReadyAt);
      checkOutput("out_valid", 32'(out_valid), 32'(v));
      checkOutput("in_ready", 32'(in_ready), 32'(!mItem || (v && ordy)));
      checkOutput("busy", 32'(busy), 32'(mItem));
      checkOutput("out_class", 32'(out_class), v ? 32'(mCls) : 32'd0);
      checkOutput("out_instr", out_instr, mInstr);
      checkOutput("out_pc", out_pc, mPc);
      checkOutput("issue_count", 32'(issue_count), 32'(mCount));
   endtask

   task automatic modelReset();
      mItem = 1'b0; mCls = '0; mInstr = '0; mPc = '0; mCount = '0;
   endtask

   // One cycle: drive at negedge, check just after, advance model on the rising edge.
   task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] p, input logic ordy);
      logic expValid;
      logic expReady;
      in_valid = v; instruction = ins; pc = p; out_ready = ordy;
      #1;
      compareAll(ordy);
      expValid = mItem && (cyc >= mReadyAt);
      expReady = !mItem || (expValid && ordy);
      @(posedge clk);
      cyc++;
      if (v && expReady) begin
         mItem = 1'b1; mCls = refClass(ins); mInstr = ins; mPc = p;
         mCount = mCount + 16'd1;
         mReadyAt = cyc + refLat(mCls) - 1;
      end else if (expValid && ordy) begin
         mItem = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic doReset();
      @(negedge clk);
      rst_n = 1'b0;
      modelReset();
      #1;
      compareAll(out_ready);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [31:0] r;
      #12;
      compareAll(1'b0);
      doReset();

      // Single alu op
      applyStimulus(1'b1, 32'h0000_0000, 32'h100, 1'b1);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
      checkOutput("alu_class", 32'(out_class), 32'h01);
      checkOutput("alu_pc", out_pc, 32'h100);
      checkOutput("alu_count", 32'(issue_count), 32'd1);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);

      // Back-to-back single-cycle classes
      for (int i = 0; i < 5; i++) begin
         r = (i % 2 == 0) ? 32'h8000_0000 : 32'h6000_0000;
         applyStimulus(1'b1, r, 32'h200 + 32'(i * 4), 1'b1);
         checkOutput("b2b_class", 32'(out_class), (i % 2 == 0) ? 32'h02 : 32'h08);
      end
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);

      // Mem op latency
      applyStimulus(1'b1, 32'h7400_0000, 32'h300, 1'b1);
      applyStimulus(1'b1, 32'h0, 32'h0, 1'b1);
      checkOutput("mem_wait_ready", 32'(in_ready), 32'd0);
      applyStimulus(1'b1, 32'h0, 32'h0, 1'b1);
      checkOutput("mem_class", 32'(out_class), 32'h10);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);

      // Float op with downstream stall
      applyStimulus(1'b1, 32'hC000_0000, 32'h400, 1'b0);
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 32'h1234, 32'h44, 1'b0);
      checkOutput("stall_class", 32'(out_class), 32'h04);
      checkOutput("stall_ready", 32'(in_ready), 32'd0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);

      // Reset during EXEC of a float op
      applyStimulus(1'b1, 32'hC400_0000, 32'h500, 1'b1);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
      doReset();
      checkOutput("rst_count", 32'(issue_count), 32'd0);
      applyStimulus(1'b1, 32'h7C00_0000, 32'h600, 1'b1);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         r = $urandom;
         applyStimulus(($urandom_range(0, 9) < 6), r, $urandom, ($urandom_range(0, 9) < 7));
      end
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);

      // Counter wrap
      doReset();
      for (int i = 0; i < 65536; i++) begin
         r = {6'($urandom_range(0, 23)), 26'($urandom)};
         applyStimulus(1'b1, r, 32'(i), 1'b1);
      end
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
      checkOutput("wrap_count", 32'(issue_count), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
